// File: rtl/threshold_capture_sampler.sv
// Hysteresis-triggered ADC frame capture: pre-trigger delay line, post-trigger tail, running counts.
// Define SAMPLER_PEAK_EN to add per-frame peak reporting on peak/peak_vld.
module threshold_capture_sampler #(
    parameter int DATA_W    = 10,
    parameter int PRE_DEPTH = 8,
    parameter int POST_LEN  = 32,
    parameter int CNT_W     = 16,
    parameter int EVT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] adc_dat,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic [DATA_W-1:0] dout,
    output logic              we,
    output logic              frame_start,
    output logic [CNT_W-1:0]  cnt,
    output logic [EVT_W-1:0]  evt_cnt,
    output logic              busy
`ifdef SAMPLER_PEAK_EN
    ,output logic [DATA_W-1:0] peak,
    output logic              peak_vld
`endif
);

    localparam int PW = (POST_LEN > 1) ? $clog2(POST_LEN) : 1;
    localparam int TW = $clog2(PRE_DEPTH + 1);
    localparam logic [PW-1:0] POST_LAST = PW'(POST_LEN - 1);
    // The tail runs one cycle past PRE_DEPTH to cover the registered output stage.
    localparam logic [TW-1:0] TAIL_LAST = TW'(PRE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_POST, S_TAIL} state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_post_cnt, w_post_nxt;
    logic [TW-1:0]     r_tail_cnt, w_tail_nxt;
    logic [DATA_W-1:0] r_dly [PRE_DEPTH];
    logic [PRE_DEPTH-1:0] r_vld;
    logic [DATA_W-1:0] r_dout;
    logic              r_we, r_fs, r_fs_pend, r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [EVT_W-1:0]  r_evt;
    logic              w_hi, w_lo, w_trig, w_we_nxt, w_fs_nxt;

    assign w_hi = adc_dat > thr_hi;
    assign w_lo = adc_dat < thr_lo;

    // NOTE: sample storage carries no reset; only the valid bits need one, which keeps the data path reset-free.
    always_ff @(posedge clk) begin
        r_dly[0] <= adc_dat;
        for (int i = 1; i < PRE_DEPTH; i++) r_dly[i] <= r_dly[i-1];
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_post_nxt  = r_post_cnt;
        w_tail_nxt  = r_tail_cnt;
        w_trig      = 1'b0;
        case (r_state)
            S_IDLE: if (en && w_hi) begin
                w_state_nxt = S_ACTIVE;
                w_trig      = 1'b1;
            end
            S_ACTIVE: if (w_lo) begin
                w_state_nxt = S_POST;
                w_post_nxt  = '0;
            end
            S_POST: begin
                if (w_hi) begin
                    w_state_nxt = S_ACTIVE;
                end else if (r_post_cnt == POST_LAST) begin
                    w_state_nxt = S_TAIL;
                    w_tail_nxt  = '0;
                end else begin
                    w_post_nxt = r_post_cnt + 1'b1;
                end
            end
            S_TAIL: begin
                if (w_hi)                          w_state_nxt = S_ACTIVE;
                else if (r_tail_cnt == TAIL_LAST)  w_state_nxt = S_IDLE;
                else                               w_tail_nxt  = r_tail_cnt + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_we_nxt = (w_state_nxt != S_IDLE) && r_vld[PRE_DEPTH-1];
    // frame_start waits for the first sample that is actually written (older-than-reset samples are skipped).
    assign w_fs_nxt = w_we_nxt && (w_trig || r_fs_pend);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_post_cnt <= '0;
            r_tail_cnt <= '0;
            r_vld      <= '0;
            r_dout     <= '0;
            r_we       <= 1'b0;
            r_fs       <= 1'b0;
            r_fs_pend  <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_evt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_post_cnt <= w_post_nxt;
            r_tail_cnt <= w_tail_nxt;
            r_vld[0]   <= 1'b1;
            for (int i = 1; i < PRE_DEPTH; i++) r_vld[i] <= r_vld[i-1];
            r_we       <= w_we_nxt;
            if (w_we_nxt) r_dout <= r_dly[PRE_DEPTH-1];
            r_fs       <= w_fs_nxt;
            r_fs_pend  <= (w_trig || r_fs_pend) && !w_we_nxt && (w_state_nxt != S_IDLE);
            r_busy     <= w_state_nxt != S_IDLE;
            if (w_we_nxt && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_trig && r_evt != '1)   r_evt <= r_evt + 1'b1;
        end
    end

    assign dout        = r_dout;
    assign we          = r_we;
    assign frame_start = r_fs;
    assign cnt         = r_cnt;
    assign evt_cnt     = r_evt;
    assign busy        = r_busy;

`ifdef SAMPLER_PEAK_EN
    logic [DATA_W-1:0] r_peak_acc, r_peak;
    logic              r_peak_vld, w_track, w_frame_end;

    // Tracks live samples from the trigger through the last POST sample, including retriggers.
    assign w_track     = (r_state == S_ACTIVE) || (r_state == S_POST) || (w_state_nxt == S_ACTIVE);
    assign w_frame_end = (r_state == S_TAIL) && (w_state_nxt == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_acc <= '0;
            r_peak     <= '0;
            r_peak_vld <= 1'b0;
        end else begin
            if (w_trig)                             r_peak_acc <= adc_dat;
            else if (w_track && adc_dat > r_peak_acc) r_peak_acc <= adc_dat;
            r_peak_vld <= w_frame_end;
            if (w_frame_end) r_peak <= r_peak_acc;
        end
    end

    assign peak     = r_peak;
    assign peak_vld = r_peak_vld;
`endif

endmodule

// File: tb/tb_threshold_capture_sampler.sv
// Directed bench for threshold_capture_sampler (PRE_DEPTH=4, POST_LEN=3, thr_hi=100, thr_lo=80).
module tb_threshold_capture_sampler;

    localparam int PRE = 4;

    logic       clk, rst_n, en;
    logic [9:0] adc_dat, thr_hi, thr_lo, dout;
    logic       we, frame_start, busy;
    logic [4:0] cnt;
    logic [1:0] evt_cnt;
`ifdef SAMPLER_PEAK_EN
    logic [9:0] peak;
    logic       peak_vld;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [9:0] smp [0:39];

    threshold_capture_sampler #(
        .DATA_W(10), .PRE_DEPTH(PRE), .POST_LEN(3), .CNT_W(5), .EVT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .adc_dat(adc_dat),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .dout(dout), .we(we),
        .frame_start(frame_start), .cnt(cnt), .evt_cnt(evt_cnt), .busy(busy)
`ifdef SAMPLER_PEAK_EN
        , .peak(peak), .peak_vld(peak_vld)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] s);
        adc_dat = s;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic fill(input logic [9:0] base, input logic [9:0] step);
        for (int i = 0; i < 40; i++) smp[i] = base + step * 10'(i);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".we"},      we,          0);
        check({tag, ".fs"},      frame_start, 0);
        check({tag, ".cnt"},     cnt,         0);
        check({tag, ".evt"},     evt_cnt,     0);
        check({tag, ".busy"},    busy,        0);
        check({tag, ".dout"},    dout,        0);
`ifdef SAMPLER_PEAK_EN
        check({tag, ".peak"},    peak,        0);
        check({tag, ".pvld"},    peak_vld,    0);
`endif
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        adc_dat = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        check_idle_outputs("reset");
    endtask

    // Runs cycles up to n_end, checking the expected write window, frame_start cycle and busy window.
    task automatic run(input int n_end, input int we_lo, input int we_hi,
                       input int fs_k, input int b_lo, input int b_hi);
        while (cyc < n_end) begin
            check($sformatf("we@%0d", cyc), we, (cyc >= we_lo && cyc <= we_hi) ? 1 : 0);
            if (cyc >= we_lo && cyc <= we_hi)
                check($sformatf("dout@%0d", cyc), dout, smp[cyc-1-PRE]);
            check($sformatf("fs@%0d", cyc), frame_start, (cyc == fs_k) ? 1 : 0);
            check($sformatf("busy@%0d", cyc), busy, (cyc >= b_lo && cyc <= b_hi) ? 1 : 0);
            drive(smp[cyc]);
        end
    endtask

    initial begin
        thr_hi  = 10'd100;
        thr_lo  = 10'd80;
        en      = 1'b1;
        rst_n   = 1'b0;
        adc_dat = '0;

        // 1: single frame s6..s14, we 11..19, busy falls at 20
        do_reset();
        fill(10'd40, 10'd1);
        smp[10] = 10'd120;
        run(25, 11, 19, 11, 11, 19);
        check("t1.cnt", cnt, 9);
        check("t1.evt", evt_cnt, 1);

        // 2: retrigger in POST extends to one frame s6..s17
        do_reset();
        fill(10'd40, 10'd1);
        smp[10] = 10'd120;
        smp[13] = 10'd120;
        run(28, 11, 22, 11, 11, 22);
        check("t2.cnt", cnt, 12);
        check("t2.evt", evt_cnt, 1);

        // 3: trigger right after reset, frame starts at s0 and ends with s6
        do_reset();
        fill(10'd40, 10'd1);
        smp[2] = 10'd120;
        run(15, 5, 11, 5, 3, 11);
        check("t3.cnt", cnt, 7);
        check("t3.evt", evt_cnt, 1);

        // 4: reset mid-frame clears outputs immediately; flat 50 afterwards writes nothing
        do_reset();
        fill(10'd40, 10'd1);
        smp[10] = 10'd120;
        run(14, 11, 19, 11, 11, 19);
        check("t4.we_pre", we, 1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("t4.async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        fill(10'd50, 10'd0);
        run(14, 1, 0, -1, 1, 0);
        check("t4.cnt", cnt, 0);

        // 5a: en low blocks the trigger
        do_reset();
        en = 1'b0;
        fill(10'd40, 10'd1);
        smp[10] = 10'd120;
        run(22, 1, 0, -1, 1, 0);
        check("t5a.evt", evt_cnt, 0);
        check("t5a.cnt", cnt, 0);

        // 5b: en dropped mid-frame, frame still completes
        do_reset();
        en = 1'b1;
        run(12, 11, 19, 11, 11, 19);
        en = 1'b0;
        run(25, 11, 19, 11, 11, 19);
        check("t5b.cnt", cnt, 9);
        check("t5b.evt", evt_cnt, 1);

        // Saturation: four 9-sample frames without reset
        do_reset();
        en = 1'b1;
        repeat (8) drive(10'd50);
        for (int f = 0; f < 4; f++) begin
            drive(10'd120);
            repeat (14) drive(10'd50);
            if (f == 2) begin
                check("sat.evt3", evt_cnt, 3);
                check("sat.cnt27", cnt, 27);
            end
        end
        check("sat.evt", evt_cnt, 3);
        check("sat.cnt", cnt, 31);

`ifdef SAMPLER_PEAK_EN
        // 6: peak of 120,150,130 reported once at frame end
        do_reset();
        fill(10'd40, 10'd1);
        smp[10] = 10'd120;
        smp[11] = 10'd150;
        smp[12] = 10'd130;
        run(21, 11, 21, 11, 11, 21);
        check("t6.pvld_pre", peak_vld, 0);
        drive(smp[cyc]);
        check("t6.pvld", peak_vld, 1);
        check("t6.peak", peak, 150);
        check("t6.busy", busy, 0);
        drive(smp[cyc]);
        check("t6.pvld_post", peak_vld, 0);
        check("t6.peak_hold", peak, 150);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/threshold_capture_sampler.md
Name: threshold_capture_sampler

Overview:
- Parametrised successor to the single-sample threshold sampler in the ADC acquisition path.
- Adds runtime hysteresis thresholds, a pre-trigger history delay line and a post-trigger tail, so that each event is written to the downstream buffer as one contiguous frame.
- Sits between the ADC capture register and the sample FIFO/BRAM write port.
- Also provides running counts of written samples and of events.

Parameters:
DATA_W, 10, ADC sample width (unsigned)
PRE_DEPTH, 8, samples written before the trigger sample (>=1)
POST_LEN, 32, samples written after the falling-threshold crossing (>=1)
CNT_W, 16, width of written-sample counter
EVT_W, 8, width of event counter

Ports:
clk  in  1  sample clock; one sample per cycle
rst_n  in  1  asynchronous active-low reset
en  in  1  arm enable; gates new triggers only
adc_dat  in  DATA_W  live ADC sample
thr_hi  in  DATA_W  trigger threshold (strictly greater than)
thr_lo  in  DATA_W  release threshold (strictly less than)
dout  out  DATA_W  delayed sample to buffer
we  out  1  write enable for dout
frame_start  out  1  high with first we of each frame
cnt  out  CNT_W  total samples written, saturating
evt_cnt  out  EVT_W  frames started, saturating
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - dout, we, frame_start, cnt, evt_cnt and busy are all 0; FSM goes to IDLE.
  - All delay-line valid bits clear.
  - Reset mid-frame aborts the frame; we drops in the same instant.
- Delay line:
  - PRE_DEPTH+1 registered stages, each holding a sample plus a valid bit; shifts every cycle regardless of state.
  - dout(k) = adc_dat(k-1-PRE_DEPTH).
  - Stages not yet filled since reset have valid=0.
- Write rule: we = window_open AND output-stage valid. dout is registered; dout holds its last value when we=0.
- FSM, evaluated on the live sample s = adc_dat:
  - IDLE: if en and s > thr_hi, go to ACTIVE, open window, pulse frame_start, evt_cnt+1. Output is observed next cycle: we=1, dout = s(t-PRE_DEPTH).
  - ACTIVE: if s < thr_lo, go to POST with post_cnt=0. The releasing sample is in the frame.
  - POST: post_cnt+1 per cycle. If s > thr_hi, go to ACTIVE (retrigger, no evt_cnt increment). After POST_LEN samples, go to TAIL with tail_cnt=0.
  - TAIL: keep the window open for PRE_DEPTH cycles to drain the delay line, then close the window and go to IDLE. If s > thr_hi in TAIL, go to ACTIVE (frame continues, no evt_cnt increment, no frame_start).
- Retrigger gating: retriggers in POST/TAIL ignore en. Dropping en mid-frame lets the frame complete normally.
- Frame contents: s(t-PRE_DEPTH) .. s(u+POST_LEN), where t is the trigger cycle and u is the first cycle with s < thr_lo. Written contiguously, one per cycle. Samples older than reset are skipped (we=0), shortening the frame.
- Threshold evaluation: thr_hi/thr_lo are compared as unsigned each cycle. thr_lo > thr_hi is legal; the rules above apply literally.
- Counters: cnt increments on each we and saturates at 2^CNT_W-1. evt_cnt increments on IDLE->ACTIVE and saturates at 2^EVT_W-1.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: SAMPLER_PEAK_EN.
- Defined:
  - Adds output peak (DATA_W): the maximum live sample from trigger up to the last POST sample of the frame.
  - Adds output peak_vld (1): a one-cycle pulse on the TAIL->IDLE transition, with peak valid and held until the next pulse.
  - Both reset to 0.
- Undefined: neither port exists and there is no peak logic.

Test Plan:
Use PRE_DEPTH=4, POST_LEN=3, thr_hi=100, thr_lo=80, en=1, and adc_dat = cycle index + 1000 offset markers where a trace needs it.
1. Reset, s=50 flat, s(10)=120, then 50 -> one frame s6..s14 (9 samples); we high cycles 11..19; frame_start at 11; cnt=9; evt_cnt=1; busy falls at 20.
2. As 1, plus s(13)=120 -> single contiguous frame s6..s17; evt_cnt=1; one frame_start.
3. s(2)=120 right after reset -> we high only for valid samples, beginning with s0; frame ends with s6; cnt=7.
4. Trigger at 10, rst_n low at 14 -> we, cnt, evt_cnt and busy are 0 asynchronously; after release, s=50 gives no writes.
5. en=0 with s(10)=120 -> no we, evt_cnt=0. Trigger at 10 with en dropped at 12 -> full 9-sample frame.
6. SAMPLER_PEAK_EN: samples 120,150,130 from cycle 10, then 50 -> peak=150, with peak_vld pulsing once at frame end.
